// File: rtl/vec_lane_sequencer_pkg.sv
// Shared definitions for the vector lane sequencer: lane geometry, pipeline
// field widths, the opcodes the sequencer recognises and its state encoding.
package vec_lane_sequencer_pkg;

   localparam int VLANE_COUNT   = 4;
   localparam int VLANE_WIDTH   = 16;
   localparam int OPCODE_WIDTH  = 8;
   localparam int REG_WIDTH     = 16;
   localparam int VREG_ID_WIDTH = 4;

   // Scalar opcode that must pass through untouched (handled by Execute).
   localparam logic [OPCODE_WIDTH-1:0] OP_ADD_D     = 8'h00;

   localparam logic [OPCODE_WIDTH-1:0] OP_VADD      = 8'h60;
   localparam logic [OPCODE_WIDTH-1:0] OP_VMOV      = 8'h61;
   localparam logic [OPCODE_WIDTH-1:0] OP_VMOVI     = 8'h62;
   localparam logic [OPCODE_WIDTH-1:0] OP_VCOMPMOV  = 8'h63;
   localparam logic [OPCODE_WIDTH-1:0] OP_VCOMPMOVI = 8'h64;

   typedef enum logic [1:0] {
      VSEQ_IDLE = 2'd0,
      VSEQ_EXEC = 2'd1,
      VSEQ_DONE = 2'd2
   } vseq_state_e;

   function automatic logic is_vec_op(input logic [OPCODE_WIDTH-1:0] op);
      return (op == OP_VADD)     || (op == OP_VMOV)     || (op == OP_VMOVI) ||
             (op == OP_VCOMPMOV) || (op == OP_VCOMPMOVI);
   endfunction

   // Single-lane ops: only the lane chosen by I_Idx is rewritten.
   function automatic logic is_compmov(input logic [OPCODE_WIDTH-1:0] op);
      return (op == OP_VCOMPMOV) || (op == OP_VCOMPMOVI);
   endfunction

endpackage

// File: rtl/vec_lane_sequencer_lane_alu.sv
// Combinational per-lane ALU shared by all lanes of the sequencer.
//   opcode : captured vector opcode
//   a      : lane of vector source 1, or the scalar source for VCOMPMOV
//   b      : lane of vector source 2
//   imm    : immediate lane value
//   result : lane result (VADD wraps modulo 2^LANE_W)
module vec_lane_sequencer_lane_alu
   import vec_lane_sequencer_pkg::*;
#(
   parameter int LANE_W = VLANE_WIDTH
) (
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic [LANE_W-1:0]       a,
   input  logic [LANE_W-1:0]       b,
   input  logic [LANE_W-1:0]       imm,
   output logic [LANE_W-1:0]       result
);

   always_comb begin
      result = '0;
      case (opcode)
         OP_VADD:                  result = a + b;
         OP_VMOV, OP_VCOMPMOV:     result = a;
         OP_VMOVI, OP_VCOMPMOVI:   result = imm;
         default:                  result = '0;
      endcase
   end

endmodule

// File: rtl/vec_lane_sequencer.sv
// Multi-cycle vector sequencer: runs one lane per cycle through a shared lane
// ALU, holds decode off while busy, honours the GPU stall and presents the
// assembled vector with a write enable while in DONE. State updates on the
// falling clock edge, like the other pipeline stages.
//   I_CLOCK, I_RESET     : clock (falling edge), synchronous active-high reset
//   I_LOCK               : pipeline enable; low aborts an op in flight
//   I_DE_Valid/I_Opcode  : decoded instruction from decode
//   I_Idx                : lane select for the COMPMOV ops
//   I_Imm, I_Src1Value   : immediate / scalar source (low LANE_W bits)
//   I_DestVRegIdx        : destination vector register
//   I_VecSrc1Value/2     : vector sources (src1 also preloads the result)
//   I_GPUStallSignal     : back-pressure, freezes EXEC and holds DONE
//   O_Busy_Signal        : high whenever not IDLE
//   O_VecDestValue       : assembled result, lane i at [i*LANE_W +: LANE_W]
//   O_DestVRegIdx        : captured destination index
//   O_VRegWEn            : vector register write enable (DONE only)
//   O_LaneIdx            : lane currently being computed
module vec_lane_sequencer
   import vec_lane_sequencer_pkg::*;
#(
   parameter int LANES  = VLANE_COUNT,
   parameter int LANE_W = VLANE_WIDTH
) (
   input  logic                     I_CLOCK,
   input  logic                     I_RESET,
   input  logic                     I_LOCK,
   input  logic                     I_DE_Valid,
   input  logic [OPCODE_WIDTH-1:0]  I_Opcode,
   input  logic [1:0]               I_Idx,
   input  logic [REG_WIDTH-1:0]     I_Imm,
   input  logic [REG_WIDTH-1:0]     I_Src1Value,
   input  logic [VREG_ID_WIDTH-1:0] I_DestVRegIdx,
   input  logic [LANES*LANE_W-1:0]  I_VecSrc1Value,
   input  logic [LANES*LANE_W-1:0]  I_VecSrc2Value,
   input  logic                     I_GPUStallSignal,
   output logic                     O_Busy_Signal,
   output logic [LANES*LANE_W-1:0]  O_VecDestValue,
   output logic [VREG_ID_WIDTH-1:0] O_DestVRegIdx,
   output logic                     O_VRegWEn,
   output logic [1:0]               O_LaneIdx
);

   localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

   vseq_state_e               state_q, state_d;
   logic                      accept;
   logic                      lane_step;

   logic [OPCODE_WIDTH-1:0]   op_q;
   logic [1:0]                lane_q;
   logic [LANES*LANE_W-1:0]   src1_q;
   logic [LANES*LANE_W-1:0]   src2_q;
   logic [LANE_W-1:0]         imm_q;
   logic [LANE_W-1:0]         scal_q;
   logic [LANES*LANE_W-1:0]   result_q;
   logic [VREG_ID_WIDTH-1:0]  dest_q;

   logic [LANE_W-1:0]         alu_a;
   logic [LANE_W-1:0]         alu_b;
   logic [LANE_W-1:0]         alu_result;

   always_ff @(negedge I_CLOCK) begin
      if (I_RESET) begin
         state_q <= VSEQ_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      lane_step = 1'b0;
      case (state_q)
         VSEQ_IDLE: begin
            if (I_LOCK && I_DE_Valid && is_vec_op(I_Opcode)) begin
               accept  = 1'b1;
               state_d = VSEQ_EXEC;
            end
         end
         VSEQ_EXEC: begin
            if (!I_LOCK) begin
               state_d = VSEQ_IDLE;
            end else if (!I_GPUStallSignal) begin
               lane_step = 1'b1;
               if (is_compmov(op_q) || (lane_q == LAST_LANE)) begin
                  state_d = VSEQ_DONE;
               end
            end
         end
         VSEQ_DONE: begin
            if (!I_LOCK || !I_GPUStallSignal) begin
               state_d = VSEQ_IDLE;
            end
         end
         default: state_d = VSEQ_IDLE;
      endcase
   end

   // VCOMPMOV takes its lane value from the scalar source, not vector src1.
   assign alu_a = is_compmov(op_q) ? scal_q : src1_q[lane_q*LANE_W +: LANE_W];
   assign alu_b = src2_q[lane_q*LANE_W +: LANE_W];

   vec_lane_sequencer_lane_alu #(
      .LANE_W (LANE_W)
   ) u_lane_alu (
      .opcode (op_q),
      .a      (alu_a),
      .b      (alu_b),
      .imm    (imm_q),
      .result (alu_result)
   );

   always_ff @(negedge I_CLOCK) begin
      if (I_RESET) begin
         op_q     <= '0;
         lane_q   <= '0;
         src1_q   <= '0;
         src2_q   <= '0;
         imm_q    <= '0;
         scal_q   <= '0;
         result_q <= '0;
         dest_q   <= '0;
      end else if (accept) begin
         op_q     <= I_Opcode;
         lane_q   <= is_compmov(I_Opcode) ? I_Idx : 2'd0;
         src1_q   <= I_VecSrc1Value;
         src2_q   <= I_VecSrc2Value;
         imm_q    <= I_Imm[LANE_W-1:0];
         scal_q   <= I_Src1Value[LANE_W-1:0];
         // Preload so lanes untouched by the COMPMOV ops keep the destination.
         result_q <= I_VecSrc1Value;
         dest_q   <= I_DestVRegIdx;
      end else if (lane_step) begin
         result_q[lane_q*LANE_W +: LANE_W] <= alu_result;
         if (!is_compmov(op_q) && (lane_q != LAST_LANE)) begin
            lane_q <= lane_q + 2'd1;
         end
      end
   end

   assign O_Busy_Signal  = (state_q != VSEQ_IDLE);
   assign O_VRegWEn      = (state_q == VSEQ_DONE);
   assign O_VecDestValue = result_q;
   assign O_DestVRegIdx  = dest_q;
   assign O_LaneIdx      = lane_q;

endmodule

// File: tb/tb_vec_lane_sequencer.sv
module tb_vec_lane_sequencer;
   import vec_lane_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        I_RESET, I_LOCK, I_DE_Valid, I_GPUStallSignal;
   logic [7:0]  I_Opcode;
   logic [1:0]  I_Idx;
   logic [15:0] I_Imm, I_Src1Value;
   logic [3:0]  I_DestVRegIdx;
   logic [63:0] I_VecSrc1Value, I_VecSrc2Value;
   logic        O_Busy_Signal, O_VRegWEn;
   logic [63:0] O_VecDestValue;
   logic [3:0]  O_DestVRegIdx;
   logic [1:0]  O_LaneIdx;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vec_lane_sequencer #(.LANES(4), .LANE_W(16)) dut (
      .I_CLOCK(clk), .I_RESET(I_RESET), .I_LOCK(I_LOCK), .I_DE_Valid(I_DE_Valid),
      .I_Opcode(I_Opcode), .I_Idx(I_Idx), .I_Imm(I_Imm), .I_Src1Value(I_Src1Value),
      .I_DestVRegIdx(I_DestVRegIdx), .I_VecSrc1Value(I_VecSrc1Value),
      .I_VecSrc2Value(I_VecSrc2Value), .I_GPUStallSignal(I_GPUStallSignal),
      .O_Busy_Signal(O_Busy_Signal), .O_VecDestValue(O_VecDestValue),
      .O_DestVRegIdx(O_DestVRegIdx), .O_VRegWEn(O_VRegWEn), .O_LaneIdx(O_LaneIdx));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: result vector as lane arrays, straight from the op rules.
   function automatic logic [63:0] model(input logic [7:0] op, input logic [1:0] idx,
                                         input logic [15:0] imm, input logic [15:0] scal,
                                         input logic [63:0] v1, input logic [63:0] v2);
      logic [15:0] a [4];
      logic [15:0] b [4];
      logic [15:0] r [4];
      logic [63:0] out;
      for (int i = 0; i < 4; i++) begin
         a[i] = v1[i*16 +: 16];
         b[i] = v2[i*16 +: 16];
         r[i] = a[i];
         case (op)
            OP_VADD:      r[i] = 16'((32'(a[i]) + 32'(b[i])) % 65536);
            OP_VMOV:      r[i] = a[i];
            OP_VMOVI:     r[i] = imm;
            OP_VCOMPMOV:  if (i == int'(idx)) r[i] = scal;
            OP_VCOMPMOVI: if (i == int'(idx)) r[i] = imm;
            default:      r[i] = a[i];
         endcase
      end
      for (int i = 0; i < 4; i++) out[i*16 +: 16] = r[i];
      return out;
   endfunction

   // Present one op, stall stall_n cycles while lane stall_lane is pending and
   // done_n cycles in DONE, then compare timing and result with the model.
   task automatic run_op(input string tag, input logic [7:0] op, input logic [1:0] idx,
                         input logic [15:0] imm, input logic [15:0] scal, input logic [3:0] dest,
                         input logic [63:0] v1, input logic [63:0] v2,
                         input int stall_lane, input int stall_n, input int done_n,
                         output logic [63:0] got);
      int busy_cnt, wen_cnt, hold, s_left, d_left, lanes;
      logic finished;
      logic [3:0] gdest;
      I_Opcode = op; I_Idx = idx; I_Imm = imm; I_Src1Value = scal; I_DestVRegIdx = dest;
      I_VecSrc1Value = v1; I_VecSrc2Value = v2; I_GPUStallSignal = 1'b0; I_DE_Valid = 1'b1;
      busy_cnt = 0; wen_cnt = 0; hold = 0; s_left = stall_n; d_left = done_n;
      finished = 1'b0; got = '0; gdest = '0;
      @(negedge clk);
      for (int c = 0; c < 64; c++) begin
         @(posedge clk);
         I_DE_Valid = 1'b0;
         if (!O_Busy_Signal) begin
            finished = 1'b1;
            break;
         end
         busy_cnt++;
         if (O_VRegWEn) begin
            wen_cnt++;
            got   = O_VecDestValue;
            gdest = O_DestVRegIdx;
         end else if (int'(O_LaneIdx) == stall_lane) begin
            hold++;
         end
         if (!O_VRegWEn && int'(O_LaneIdx) == stall_lane && s_left > 0) begin
            I_GPUStallSignal = 1'b1; s_left--;
         end else if (O_VRegWEn && d_left > 0) begin
            I_GPUStallSignal = 1'b1; d_left--;
         end else begin
            I_GPUStallSignal = 1'b0;
         end
         @(negedge clk);
      end
      I_GPUStallSignal = 1'b0;
      lanes = is_compmov(op) ? 1 : 4;
      check({tag, "_finished"}, 64'(finished), 64'd1);
      check({tag, "_busy"}, 64'(busy_cnt), 64'(lanes + stall_n + 1 + done_n));
      check({tag, "_wen"}, 64'(wen_cnt), 64'(1 + done_n));
      check({tag, "_result"}, got, model(op, idx, imm, scal, v1, v2));
      check({tag, "_dest"}, 64'(gdest), 64'(dest));
      check({tag, "_lanehold"}, 64'(hold), 64'(1 + stall_n));
   endtask

   logic [7:0]  vec_ops [5];
   logic [63:0] got;
   logic [63:0] res [2];
   logic [3:0]  dst [2];
   logic [7:0]  rop;
   logic [1:0]  ridx;
   int          pulses, slane;
   logic        seen, reached, done2;

   initial begin
      vec_ops = '{OP_VADD, OP_VMOV, OP_VMOVI, OP_VCOMPMOV, OP_VCOMPMOVI};
      I_RESET = 1'b1; I_LOCK = 1'b1; I_DE_Valid = 1'b0; I_GPUStallSignal = 1'b0;
      I_Opcode = '0; I_Idx = '0; I_Imm = '0; I_Src1Value = '0; I_DestVRegIdx = '0;
      I_VecSrc1Value = '0; I_VecSrc2Value = '0;
      @(negedge clk); @(negedge clk);
      @(posedge clk);
      I_RESET = 1'b0;
      check("rst_busy", 64'(O_Busy_Signal), 64'd0);
      check("rst_value", O_VecDestValue, 64'd0);
      check("rst_dest", 64'(O_DestVRegIdx), 64'd0);
      check("rst_wen", 64'(O_VRegWEn), 64'd0);
      check("rst_lane", 64'(O_LaneIdx), 64'd0);

      // VADD with lane 0 wrap
      run_op("vadd", OP_VADD, 2'd0, 16'h0, 16'h0, 4'd5, 64'h0004_0003_0002_0001,
             64'h0010_0010_0010_FFFF, 0, 0, 0, got);
      check("vadd_literal", got, 64'h0014_0013_0012_0000);

      // VCOMPMOVI into lane 2
      run_op("compmovi", OP_VCOMPMOVI, 2'd2, 16'h00AB, 16'h0, 4'd9, 64'h1111_2222_3333_4444,
             64'h0, 2, 0, 0, got);
      check("compmovi_literal", got, 64'h1111_00AB_3333_4444);

      // VADD with a 3-cycle stall while lane 1 is pending
      run_op("vadd_stall", OP_VADD, 2'd0, 16'h0, 16'h0, 4'd6, 64'h0004_0003_0002_0001,
             64'h0010_0010_0010_FFFF, 1, 3, 0, got);
      check("vadd_stall_literal", got, 64'h0014_0013_0012_0000);

      // Reset pulsed while lane 2 is pending
      I_Opcode = OP_VADD; I_DestVRegIdx = 4'd7; I_VecSrc1Value = 64'h0004_0003_0002_0001;
      I_VecSrc2Value = 64'h0010_0010_0010_FFFF; I_DE_Valid = 1'b1;
      seen = 1'b0; reached = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         I_DE_Valid = 1'b0;
         if (O_VRegWEn) seen = 1'b1;
         if (O_LaneIdx == 2'd2) begin
            reached = 1'b1;
            I_RESET = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      @(posedge clk);
      I_RESET = 1'b0;
      check("midrst_reached", 64'(reached), 64'd1);
      check("midrst_busy", 64'(O_Busy_Signal), 64'd0);
      check("midrst_value", O_VecDestValue, 64'd0);
      check("midrst_dest", 64'(O_DestVRegIdx), 64'd0);
      check("midrst_lane", 64'(O_LaneIdx), 64'd0);
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         if (O_VRegWEn || O_Busy_Signal) seen = 1'b1;
      end
      check("midrst_nowen", 64'(seen), 64'd0);

      // Abort by dropping I_LOCK while lane 1 is pending
      I_Opcode = OP_VMOV; I_DE_Valid = 1'b1; seen = 1'b0; reached = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         I_DE_Valid = 1'b0;
         if (O_VRegWEn) seen = 1'b1;
         if (O_LaneIdx == 2'd1) begin
            reached = 1'b1;
            I_LOCK = 1'b0;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      @(posedge clk);
      I_LOCK = 1'b1;
      check("abort_reached", 64'(reached), 64'd1);
      check("abort_busy", 64'(O_Busy_Signal), 64'd0);
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         if (O_VRegWEn || O_Busy_Signal) seen = 1'b1;
      end
      check("abort_nowen", 64'(seen), 64'd0);

      // Scalar opcode is ignored
      I_Opcode = OP_ADD_D; I_DE_Valid = 1'b1; seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         @(posedge clk);
         if (O_Busy_Signal || O_VRegWEn) seen = 1'b1;
      end
      I_DE_Valid = 1'b0;
      check("scalar_ignored", 64'(seen), 64'd0);

      // VMOVI then VMOV back-to-back, decode holding the second op while busy
      I_Opcode = OP_VMOVI; I_Imm = 16'h0007; I_DestVRegIdx = 4'd3;
      I_VecSrc1Value = {$urandom, $urandom}; I_DE_Valid = 1'b1;
      pulses = 0; done2 = 1'b0; res[0] = '0; res[1] = '0; dst[0] = '0; dst[1] = '0;
      @(negedge clk);
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         if (c == 0) begin
            I_Opcode = OP_VMOV; I_DestVRegIdx = 4'd12; I_VecSrc1Value = 64'h0001_0002_0003_0004;
         end
         if (O_Busy_Signal && !O_VRegWEn && pulses == 1) I_DE_Valid = 1'b0;
         if (O_VRegWEn) begin
            if (pulses < 2) begin
               res[pulses] = O_VecDestValue;
               dst[pulses] = O_DestVRegIdx;
            end
            pulses++;
         end
         if (pulses >= 2 && !O_Busy_Signal) begin
            done2 = 1'b1;
            break;
         end
         @(negedge clk);
      end
      I_DE_Valid = 1'b0;
      check("b2b_finished", 64'(done2), 64'd1);
      check("b2b_pulses", 64'(pulses), 64'd2);
      check("b2b_res0", res[0], 64'h0007_0007_0007_0007);
      check("b2b_dest0", 64'(dst[0]), 64'd3);
      check("b2b_res1", res[1], 64'h0001_0002_0003_0004);
      check("b2b_dest1", 64'(dst[1]), 64'd12);

      // Randomized ops with random stalls in EXEC and DONE
      for (int t = 0; t < 16; t++) begin
         rop   = vec_ops[$urandom_range(0, 4)];
         ridx  = 2'($urandom_range(0, 3));
         slane = is_compmov(rop) ? int'(ridx) : int'($urandom_range(0, 3));
         run_op("rand", rop, ridx, 16'($urandom), 16'($urandom), 4'($urandom),
                {$urandom, $urandom}, {$urandom, $urandom}, slane,
                int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), got);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vec_lane_sequencer.md
# vec_lane_sequencer

Multi-cycle sequencer that runs vector instructions over one shared 16-bit lane ALU, one lane per cycle, alongside the Execute stage. It accepts a vector op from decode, holds off decode while the op is in flight, and honours the GPU stall. It then presents the assembled vector result with a one-cycle vector-register write enable. Scalar opcodes are ignored and keep using the scalar ALU in Execute.

## Interface
- LANES, 4, number of vector lanes; `VREG_WIDTH = LANES*LANE_W
- LANE_W, 16, lane width in bits
- I_CLOCK  in  1  pipeline clock; all state updates on its falling edge, like the other stages
- I_RESET  in  1  synchronous, active-high reset
- I_LOCK  in  1  pipeline enable; low aborts any op in flight
- I_DE_Valid  in  1  decode-stage instruction valid
- I_Opcode  in  `OPCODE_WIDTH  decoded opcode
- I_Idx  in  2  lane select for VCOMPMOV/VCOMPMOVI
- I_Imm  in  `REG_WIDTH  immediate; bits [LANE_W-1:0] used
- I_Src1Value  in  `REG_WIDTH  scalar source; bits [LANE_W-1:0] used
- I_DestVRegIdx  in  `VREG_ID_WIDTH  destination vector register
- I_VecSrc1Value  in  `VREG_WIDTH  vector source 1; current destination contents for the COMPMOV ops
- I_VecSrc2Value  in  `VREG_WIDTH  vector source 2
- I_GPUStallSignal  in  1  back-pressure from the GPU stage
- O_Busy_Signal  out  1  combinational; high whenever state ≠ IDLE; decode must hold
- O_VecDestValue  out  `VREG_WIDTH  assembled result; lane i = bits [i*LANE_W +: LANE_W]
- O_DestVRegIdx  out  `VREG_ID_WIDTH  captured destination index
- O_VRegWEn  out  1  high only in DONE
- O_LaneIdx  out  2  lane being computed, for debug

## Operation
- **States:** IDLE, EXEC, DONE.
- **IDLE:** an op is accepted when I_LOCK=1, I_DE_Valid=1 and I_Opcode is one of VADD, VMOV, VMOVI, VCOMPMOV or VCOMPMOVI.
  - On acceptance, capture the sources, Imm and DestVRegIdx, and preload the result register with I_VecSrc1Value.
  - Lane counter is set to 0, or to I_Idx for the COMPMOV ops.
  - Go to EXEC.
  - Any other opcode: stay in IDLE with no effect.
- **EXEC, I_GPUStallSignal=0:** write the lane_alu output into the result lane selected by the counter.
  - VADD: src1+src2, modulo 2^16, no carry between lanes.
  - VMOV: src1.
  - VMOVI: Imm.
  - VCOMPMOV: Src1Value.
  - VCOMPMOVI: Imm.
  - Full-vector ops: increment the counter; when counter = LANES-1, go to DONE.
  - COMPMOV ops: go to DONE after their single lane; the other lanes keep their preloaded values.
- **EXEC, I_GPUStallSignal=1:** counter and result frozen.
- **DONE:** O_VRegWEn=1 and O_VecDestValue is valid.
  - I_GPUStallSignal=1: hold DONE, with WEn held high.
  - I_GPUStallSignal=0: go to IDLE.
- **Abort:** I_LOCK=0 in EXEC or DONE forces IDLE at the next edge, with no write enable.
- **Reset:** I_RESET=1 at any edge overrides everything.
  - State becomes IDLE and the counter 0.
  - O_VecDestValue, O_DestVRegIdx, O_VRegWEn and O_LaneIdx all become 0, and O_Busy_Signal goes low.
  - Reset mid-op discards the op; no WEn is ever produced for it.

## Timing
- Acceptance at edge N; O_Busy_Signal is high from edge N, so decode holds the next instruction.
- Full-vector op, no stall: EXEC at edges N+1..N+4, DONE during N+4..N+5, IDLE at N+5, busy for 5 cycles.
- COMPMOV op: EXEC for 1 cycle, DONE for 1 cycle, busy for 2 cycles.
- Each stall cycle in EXEC or DONE adds exactly one cycle.
- The next vector op can be accepted at the earliest in the cycle after the return to IDLE; there is no accept from DONE.
- O_VRegWEn is high for exactly 1 cycle per completed op when there is no stall.

## Structure
- Add to global_def.h: `VLANE_COUNT and `VLANE_WIDTH, plus state encodings `VSEQ_IDLE/`VSEQ_EXEC/`VSEQ_DONE (2 bits).
- Opcode macros already live in global_def.h.
- One sub-module, **lane_alu**: combinational; inputs opcode, a, b, imm; output a 16-bit lane result.

## Test plan
- VADD, src1=0x0004_0003_0002_0001, src2=0x0010_0010_0010_FFFF -> O_VecDestValue=0x0014_0013_0012_0000 (lane 0 wraps); single-cycle WEn; busy for 5 cycles.
- VCOMPMOVI, Idx=2, Imm=0x00AB, VecSrc1=0x1111_2222_3333_4444 -> 0x1111_00AB_3333_4444; busy for 2 cycles.
- VADD as in the first test with I_GPUStallSignal high for 3 cycles while O_LaneIdx=1 -> same result; busy for 8 cycles; lane index holds at 1 during the stall.
- I_RESET pulsed while O_LaneIdx=2 -> IDLE at the next edge; all outputs 0; O_VRegWEn never rises.
- Scalar OP_ADD_D with I_DE_Valid=1 -> not accepted; O_Busy_Signal stays 0.
- VMOVI Imm=0x7 then VMOV src1=0x0001_0002_0003_0004 back-to-back, decode holding while busy -> results 0x0007_0007_0007_0007, then 0x0001_0002_0003_0004; two WEn pulses with the matching DestVRegIdx.
